// File: rtl/key_tx_pkg.sv
// ---------------------------------------------------------------------------
// key_tx_pkg : shared FSM encoding, defaults and width helper for key_tx. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package key_tx_pkg;

  localparam int KEY_BITS_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  // Number of bits needed to hold the value itself (not value-1).
  function automatic int clog2w(input int value);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_tx_tick.sv
// ---------------------------------------------------------------------------
// key_tx_tick : loadable down-counter, tick during the last cycle of a load. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_tx_tick #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] count;

  // Load value N makes tick visible in the N-th cycle after the load; holds at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tick = enable && (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/key_tx.sv
// ---------------------------------------------------------------------------
// key_tx : 64-bit key serializer onto en/sclk/sdat; KEY_TX_AUTO_EN adds heartbeat. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module key_tx
  import key_tx_pkg::*;
#(
  parameter int CLK_DIV       = 8,
  parameter int KEY_BITS      = KEY_BITS_DEFAULT,
  parameter int PERIOD_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [KEY_BITS-1:0] key,
  input  logic                key_load,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                en,
  output logic                sclk,
  output logic                sdat
);

  localparam int BCW = clog2w(KEY_BITS);

  if (CLK_DIV < 2 || CLK_DIV > 255 || PERIOD_CYCLES < 1) begin : g_bad_param
    $error("key_tx: illegal CLK_DIV or PERIOD_CYCLES");
  end

  state_t              state;
  logic [KEY_BITS-1:0] shadow;
  logic [KEY_BITS-1:0] shreg;
  logic [KEY_BITS-1:0] frame_key;
  logic                key_loaded;
  logic [BCW-1:0]      bit_cnt;
  logic                half_tick;
  logic                half_load;
  logic                start_int;
  logic                go;

`ifdef KEY_TX_AUTO_EN
  localparam int PW = clog2w(PERIOD_CYCLES);
  logic auto_tick;
  logic timer_load;

  assign timer_load = (key_load && !key_loaded) || (key_loaded && (start || auto_tick));

  key_tx_tick #(.WIDTH(PW)) u_period (
    .clk      (clk),
    .rst      (rst),
    .enable   (key_loaded),
    .load     (timer_load),
    .load_val (PW'(PERIOD_CYCLES)),
    .tick     (auto_tick)
  );

  assign start_int = start || auto_tick;
`else
  assign start_int = start;
`endif

  // A key_load coinciding with start is bypassed straight into the frame.
  assign frame_key = key_load ? key : shadow;
  assign go        = start_int && (key_loaded || key_load) && (state == IDLE);
  assign half_load = go || ((state != IDLE) && half_tick);

  key_tx_tick #(.WIDTH(8)) u_half (
    .clk      (clk),
    .rst      (rst),
    .enable   (1'b1),
    .load     (half_load),
    .load_val (8'(CLK_DIV)),
    .tick     (half_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      en         <= 1'b0;
      sclk       <= 1'b0;
      sdat       <= 1'b0;
      key_loaded <= 1'b0;
      shadow     <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (key_load) begin
        shadow     <= key;
        key_loaded <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (go) begin
            state   <= SETUP;
            busy    <= 1'b1;
            en      <= 1'b1;
            sclk    <= 1'b0;
            shreg   <= frame_key;
            sdat    <= frame_key[KEY_BITS-1];
            bit_cnt <= '0;
          end
        end
        SETUP: begin
          if (half_tick) begin
            state   <= HIGH;
            sclk    <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (half_tick) begin
            state <= LOW;
            sclk  <= 1'b0;
            if (bit_cnt < BCW'(KEY_BITS)) begin
              shreg <= shreg << 1;
              sdat  <= shreg[KEY_BITS-2];
            end
          end
        end
        LOW: begin
          if (half_tick) begin
            if (bit_cnt < BCW'(KEY_BITS)) begin
              state   <= HIGH;
              sclk    <= 1'b1;
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              state <= IDLE;
              en    <= 1'b0;
              busy  <= 1'b0;
              sdat  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_tx.sv
// ---------------------------------------------------------------------------
// tb_key_tx : scoreboard bench for key_tx; KEY_TX_AUTO_EN selects heartbeat run. Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_key_tx;

`ifdef KEY_TX_AUTO_EN
  localparam int CLK_DIV = 2;
  localparam int PERIOD  = 5000;
`else
  localparam int CLK_DIV = 8;
  localparam int PERIOD  = 50000000;
`endif
  localparam int KB        = 64;
  localparam int FRAME_CYC = (2 * KB + 1) * CLK_DIV;

  localparam logic [63:0] K1 = 64'h00AB_CDEF_0123_4567;
  localparam logic [63:0] K3 = 64'h8123_4567_89AB_CDEF;
  localparam logic [63:0] K4 = 64'hC3A5_0F1E_2D3C_4B5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key = '0;
  logic        key_load = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, en, sclk, sdat;

  key_tx #(.CLK_DIV(CLK_DIV), .KEY_BITS(KB), .PERIOD_CYCLES(PERIOD)) dut (
    .clk(clk), .rst(rst), .key(key), .key_load(key_load), .start(start),
    .busy(busy), .done(done), .en(en), .sclk(sclk), .sdat(sdat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] exp_q[$];
  int          starts[$];
  int          cyc = 0;
  int          load_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: MSB-first shift on each sclk rise inside en, sampled mid-cycle.
  logic        prev_sclk = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  logic [63:0] rx = '0;
  int          rises = 0, busy_len = 0, done_cnt = 0, total_rises = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx = '0; rises = 0; busy_len = 0;
      prev_sclk = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        rx = '0; rises = 0; busy_len = 0;
        starts.push_back(cyc);
      end
      if (busy) busy_len++;
      if (en && sclk && !prev_sclk) begin
        rx = {rx[62:0], sdat};
        rises++;
        total_rises++;
      end
      if (done) begin
        done_cnt++;
        check("done_one_cycle", prev_done, 1'b0);
        check("busy_low_at_done", {busy, en, sdat}, 3'b000);
        if (exp_q.size() == 0) check("unexpected_done", 1'b1, 1'b0);
        else begin
          check("rx_key", rx, exp_q.pop_front());
          check("sclk_rises", rises, KB);
          check("busy_cycles", busy_len, FRAME_CYC);
        end
      end
      prev_sclk = sclk; prev_busy = busy; prev_done = done;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [63:0] k);
    key = k; key_load = 1'b1;
    @(posedge clk); #1;
    load_cyc = cyc;
    key_load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_timeout", done_cnt != d0, 1'b1);
  endtask

  initial begin
    int d0, r0, n;
    logic act;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset_outputs", {busy, done, en, sclk, sdat}, 5'b00000);

`ifdef KEY_TX_AUTO_EN
    repeat (3) exp_q.push_back(K4);
    do_load(K4);
    wait_done(PERIOD + FRAME_CYC + 100);
    wait_done(PERIOD + 100);
    wait_done(PERIOD + 100);
    check("auto_frames", starts.size(), 3);
    if (starts.size() >= 3) begin
      check("auto_first_start", starts[0] - load_cyc, PERIOD);
      check("auto_period_1", starts[1] - starts[0], PERIOD);
      check("auto_period_2", starts[2] - starts[1], PERIOD);
    end
`else
    // Start without a loaded key: nothing happens.
    do_start();
    act = 1'b0;
    repeat (2000) begin
      @(negedge clk);
      act = act | busy | en | sclk;
    end
    #1;
    check("nokey_activity", act, 1'b0);
    check("nokey_done", done_cnt, 0);

    // Basic frame.
    do_load(K1);
    exp_q.push_back(K1);
    do_start();
    check("first_cycle", {busy, en, sclk, sdat}, {3'b110, K1[63]});
    wait_done(FRAME_CYC + 50);
    check("basic_done_count", done_cnt, 1);

    // Second start mid-frame is ignored.
    d0 = done_cnt; r0 = total_rises;
    exp_q.push_back(K1);
    do_start();
    idle(100);
    do_start();
    wait_done(FRAME_CYC + 50);
    idle(FRAME_CYC + 50);
    check("collision_dones", done_cnt - d0, 1);
    check("collision_rises", total_rises - r0, KB);

    // Mid-frame key_load only affects the following frame.
    do_load(64'hFFFF_FFFF_FFFF_FFFF);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    do_start();
    check("ones_first_bit", sdat, 1'b1);
    idle(200);
    do_load(64'h1);
    wait_done(FRAME_CYC + 50);
    exp_q.push_back(64'h1);
    do_start();
    check("one_first_bit", sdat, 1'b0);
    wait_done(FRAME_CYC + 50);

    // start and key_load together: new key goes out immediately.
    exp_q.push_back(K3);
    key = K3; key_load = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0; start = 1'b0;
    check("bypass_first_bit", sdat, K3[63]);
    wait_done(FRAME_CYC + 50);

    // Reset after 20 rises aborts the frame.
    do_load(K4);
    do_start();
    d0 = done_cnt;
    n = 0;
    while (rises < 20 && n < FRAME_CYC) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("reach_20_rises", rises >= 20, 1'b1);
    check("frame_active", en, 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {busy, en, sclk, sdat}, 4'b0000);
    idle(3);
    rst = 1'b0;
    idle(FRAME_CYC);
    check("abort_no_done", done_cnt - d0, 0);
    do_load(K4);
    exp_q.push_back(K4);
    do_start();
    wait_done(FRAME_CYC + 50);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
